// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// No logic; compile-time only.
// Not applicable (no handshake).
package adder_pkg;

    // Operation encoding on the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Default geometry
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Number of pipeline stages, one CHUNK-bit slice per stage
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_1_bit.sv
// Single-bit full adder cell.
// Purely combinational, zero latency.
// No handshake.
module adder_1_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry adder built from adder_1_bit cells.
// Purely combinational, zero latency.
// No handshake; also exposes the carry into the MSB for signed overflow.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    // Each bit keeps its own carry nets so the ripple chain is a set of
    // distinct signals rather than one self-referencing vector.
    for (genvar g = 0; g < CHUNK; g++) begin : g_bit
        logic ci;
        logic co;

        if (g == 0) begin : g_first
            assign ci = c_in;
        end else begin : g_rest
            assign ci = g_bit[g-1].co;
        end

        adder_1_bit u_bit (
            .a     (a[g]),
            .b     (b[g]),
            .c_in  (ci),
            .sum   (sum[g]),
            .c_out (co)
        );
    end

    assign c_out = g_bit[CHUNK-1].co;
    assign c_msb = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, carry registered between stages.
// Latency STAGES cycles from accept to out_valid; throughput 1 op/cycle.
// Full backpressure: a stage advances only when its successor is empty or advancing; in_ready = en[0].
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] LOW_MASK = {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}};

    // Per-stage registers: valid, operands (b already inverted for sub),
    // carry into this stage's slice, and the low sum bits resolved so far.
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  op_a [STAGES];
    logic [WIDTH-1:0]  op_b [STAGES];
    logic [WIDTH-1:0]  psum [STAGES];
    logic              cry  [STAGES];

    // Combinational results of each stage's slice adder
    logic [CHUNK-1:0]  slice_sum [STAGES];
    logic              slice_co  [STAGES];
    logic              slice_cm  [STAGES];
    logic [WIDTH-1:0]  merged    [STAGES];

    // Advance enables; en[i] is the flattened form of
    // en[i] = !vld[i+1] | en[i+1], so no bit depends on another bit of en.
    logic [STAGES-1:0] en;
    logic              en_out;

    assign en_out   = !out_valid || out_ready;
    assign en[LAST] = en_out;
    assign in_ready = en[0];

    for (genvar g = 0; g < LAST; g++) begin : g_en
        assign en[g] = en_out || !(&vld[LAST:g+1]);
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (op_a[g][g*CHUNK +: CHUNK]),
            .b     (op_b[g][g*CHUNK +: CHUNK]),
            .c_in  (cry[g]),
            .sum   (slice_sum[g]),
            .c_out (slice_co[g]),
            .c_msb (slice_cm[g])
        );

        // Partial sum with this stage's slice filled in
        assign merged[g] = (psum[g] & ~(LOW_MASK << (g*CHUNK)))
                         | (WIDTH'(slice_sum[g]) << (g*CHUNK));
    end

    // Valid bits: shift forward where enabled; reset discards in-flight ops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (en[0]) vld[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) vld[i] <= vld[i-1];
            end
            if (en_out) out_valid <= vld[LAST];
        end
    end

    // Stage payloads: stage 0 captures operands, later stages take the predecessor's result
    always_ff @(posedge clk) begin
        if (en[0]) begin
            op_a[0] <= a;
            op_b[0] <= (sub == SUB) ? ~b : b;
            cry[0]  <= sub;
            psum[0] <= '0;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (en[i]) begin
                op_a[i] <= op_a[i-1];
                op_b[i] <= op_b[i-1];
                cry[i]  <= slice_co[i-1];
                psum[i] <= merged[i-1];
            end
        end
    end

    // Output register: final sum and flags, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (en_out && vld[LAST]) begin
            sum      <= merged[LAST];
            c_out    <= slice_co[LAST];
            overflow <= slice_cm[LAST] ^ slice_co[LAST];
            zero     <= (merged[LAST] == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, CHUNK=8).
// Reference results come from plain wide arithmetic; a queue holds expected results in issue order.
// Exercises latency, wrap/overflow flags, streaming, stall/hold, drain and mid-flight reset.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int ST = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
        logic         zero;
        int           acc_edge;
        bit           lat;
    } exp_t;

    exp_t q[$];
    exp_t next_exp;
    int   checks   = 0;
    int   errors   = 0;
    int   edges    = 0;
    int   accepts  = 0;
    int   emitted  = 0;
    bit   lat_on   = 1'b1;

    // Reference: a + (sub ? ~b : b) + sub in W+1 bits; signed overflow when
    // both addends share a sign and the result's sign differs.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
        exp_t         m;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb         = vs ? ~vb : vb;
        full       = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, vs};
        m.sum      = full[W-1:0];
        m.c_out    = full[W];
        m.ovf      = (va[W-1] == bb[W-1]) && (full[W-1] != va[W-1]);
        m.zero     = (full[W-1:0] == '0);
        m.acc_edge = 0;
        m.lat      = 1'b0;
        return m;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov, input logic z);
        exp_t m;
        m.sum = s; m.c_out = co; m.ovf = ov; m.zero = z;
        m.acc_edge = 0; m.lat = 1'b0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock: called at a negedge with inputs already driven. Scores any
    // output transfer, records any input transfer, then advances to the next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    emitted++;
                    chk("sum",      sum,            e.sum);
                    chk("c_out",    32'(c_out),     32'(e.c_out));
                    chk("overflow", 32'(overflow),  32'(e.ovf));
                    chk("zero",     32'(zero),      32'(e.zero));
                    if (e.lat) chk("latency", 32'(edges - e.acc_edge), 32'(ST));
                end
            end
            if (in_valid && in_ready) begin
                e          = next_exp;
                e.acc_edge = edges + 1;
                e.lat      = lat_on;
                q.push_back(e);
                accepts++;
            end
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs, input exp_t ve);
        int n;
        n        = accepts;
        a        = va;
        b        = vb;
        sub      = vs;
        next_exp = ve;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && accepts == n; k++) cycle();
        in_valid = 1'b0;
        chk("accepted", 32'(accepts - n), 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
        for (int k = 0; k < 3; k++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, hs;
        logic         rs, hc, ho, hz;
        bit           have;
        int           n0, e0;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = ADD;
        next_exp = mk('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       sum,            32'd0);
        chk("rst_c_out",     32'(c_out),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        cycle();

        // Carry across a slice boundary
        lat_on = 1'b1;
        send(32'h0000FFFF, 32'h00000001, ADD, mk(32'h00010000, 1'b0, 1'b0, 1'b0));
        drain();

        // Full wrap to zero, then positive signed overflow
        send(32'hFFFFFFFF, 32'h00000001, ADD, mk(32'h00000000, 1'b1, 1'b0, 1'b1));
        send(32'h7FFFFFFF, 32'h00000001, ADD, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
        drain();

        // Subtraction: negative overflow without borrow, then a borrow
        send(32'h80000000, 32'h00000001, SUB, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
        send(32'h00000005, 32'h00000007, SUB, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
        drain();

        // Eight back-to-back random ops; fixed latency for each implies consecutive results
        e0 = emitted;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        chk("b2b_count", 32'(emitted - e0), 32'd8);

        // Stall the consumer while streaming: five ops fill the pipe, output holds
        lat_on = 1'b0; out_ready = 1'b0; n0 = accepts; have = 1'b0;
        hs = '0; hc = 1'b0; ho = 1'b0; hz = 1'b0;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 6);
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
            a = ra; b = rb; sub = rs; next_exp = model(ra, rb, rs);
            if (c == 5) begin
                #1;
                chk("in_ready_full", 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                if (!have) begin
                    have = 1'b1; hs = sum; hc = c_out; ho = overflow; hz = zero;
                end else begin
                    chk("hold_sum",      sum,           hs);
                    chk("hold_c_out",    32'(c_out),    32'(hc));
                    chk("hold_overflow", 32'(overflow), 32'(ho));
                    chk("hold_zero",     32'(zero),     32'(hz));
                end
            end
            cycle();
        end
        chk("stall_accepts",   32'(accepts - n0), 32'd5);
        chk("stall_out_valid", 32'(out_valid),    32'd1);
        e0 = emitted;
        drain();
        chk("stall_drained", 32'(emitted - e0), 32'd5);

        // Reset with three ops in flight: none may emerge afterwards
        lat_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        chk("inflight_before_rst", 32'(q.size()), 32'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        e0 = emitted;
        for (int k = 0; k < 8; k++) cycle();
        chk("post_rst_no_emit", 32'(emitted - e0), 32'd0);
        ra = $urandom; rb = $urandom;
        send(ra, rb, ADD, model(ra, rb, ADD));
        drain();
        chk("post_rst_op_done", 32'(emitted - e0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
